// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: feeds one operand bit pair per clock (LSB first) and collects the result.
// Optional signed-overflow output is enabled with `define SERIAL_ALU_OVF_EN.
module serial_alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero,
`ifdef SERIAL_ALU_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready=1
  // SHIFT | processing one bit per clock, LSB first
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [2:0]       op;
  logic             carry, carry_nxt;
  logic [CW-1:0]    count;
  logic             is_sub, is_arith, bit_a, bit_b, bit_r, last_step;

  assign is_sub    = (op == 3'b101);
  assign is_arith  = (op == 3'b100) || is_sub;
  assign bit_a     = a_sr[0];
  assign bit_b     = b_sr[0] ^ is_sub;
  assign carry_nxt = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
  assign res_nxt   = {bit_r, res_sr[WIDTH-1:1]};
  assign last_step = (count == LAST);

  always_comb begin
    bit_r = bit_a;
    case (op)
      3'b000:         bit_r = bit_a & b_sr[0];
      3'b001:         bit_r = bit_a | b_sr[0];
      3'b010:         bit_r = bit_a ^ b_sr[0];
      3'b011:         bit_r = ~bit_a;
      3'b100, 3'b101: bit_r = bit_a ^ bit_b ^ carry;
      default:        bit_r = bit_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Result registers update only on the final bit step so they hold through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op     <= 3'b000;
      carry  <= 1'b0;
      count  <= '0;
      out    <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= A;
          b_sr  <= B;
          op    <= S;
          carry <= (S == 3'b101);
          count <= '0;
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          count  <= count + CW'(1);
          if (is_arith) carry <= carry_nxt;
          if (last_step) begin
            out  <= res_nxt;
            zero <= (res_nxt == '0);
            cout <= is_arith & carry_nxt;
`ifdef SERIAL_ALU_OVF_EN
            ovf  <= is_arith & (carry ^ carry_nxt);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
